mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory-side port between two cache controllers (e.g. I-cache and D-cache
//  FSMs). Round-robin grant, one outstanding transaction, holds memory request fields stable
//  until memory acknowledges, returns read data plus a one-cycle ready pulse to the winner.
//  Watchdog aborts a transaction the memory never acknowledges. Sits between caches and memory.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width (word or line, same both sides)
//  TIMEOUT  64   cycles in ISSUE before abort; 0 disables watchdog
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  req0_valid  in   1       requester 0 transaction request (level, held until ready)
//  req0_rw     in   1       1 = write, 0 = read
//  req0_addr   in   ADDR_W  address
//  req0_wdata  in   DATA_W  write data
//  req0_ready  out  1       one-cycle completion pulse
//  req0_rdata  out  DATA_W  read data, valid while req0_ready=1
//  req0_err    out  1       with req0_ready: transaction aborted by watchdog
//  req1_*      same set as req0_*, for requester 1
//  mem_valid   out  1       memory request (level)
//  mem_rw      out  1       1 = write
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_ready   in   1       memory completion pulse
//  mem_rdata   in   DATA_W  memory read data, valid with mem_ready
//  grant       out  1       id of requester owning current/last transaction
//  busy        out  1       1 in ISSUE or DONE
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; last_grant=1 so requester 0 wins first tie.
//  - States IDLE -> ISSUE -> DONE -> IDLE; all outputs registered.
//  - IDLE: if neither valid, stay. If one valid, grant it. If both, grant !last_grant.
//    On grant: latch rw/addr/wdata of winner, set grant, last_grant, mem_valid=1 -> ISSUE.
//  - ISSUE: mem_valid/rw/addr/wdata held constant. Watchdog counter cleared on entry,
//    +1 per cycle. On mem_ready: capture mem_rdata into winner's rdata, drop mem_valid,
//    pulse winner's ready (err=0) -> DONE. If TIMEOUT!=0 and counter reaches TIMEOUT-1
//    without mem_ready: drop mem_valid, pulse ready with err=1, rdata=0 -> DONE.
//    mem_ready on the same cycle as the timeout takes precedence (normal completion).
//  - DONE: ready/err pulse high exactly this one cycle; loser's ready stays 0 -> IDLE.
//  - Latency: valid seen in IDLE cycle T -> mem_valid at T+1; mem_ready in cycle M ->
//    ready at M+1; IDLE at M+2. Minimum 3 cycles per transaction, no back-to-back overlap.
//  - Requester contract: drop valid (or present next request) the cycle after ready.
//    Valid dropped mid-transaction is ignored; transaction completes and ready still pulses.
//  - Request field changes after grant are ignored (latched copy drives memory).
//  - mem_ready outside ISSUE is ignored. Non-winning requester's rdata holds last value.
//  - Fairness: with both requesters continuously valid, grants strictly alternate.
//  - Reset mid-transaction: mem_valid and ready drop immediately; no completion pulse.
// TESTING
//  1 Single read: req0 read addr 0x40, mem_ready 2 cycles after mem_valid, rdata 0xDEADBEEF
//    -> mem_addr=0x40 mem_rw=0, req0_ready one pulse with rdata 0xDEADBEEF, req1_ready=0.
//  2 Simultaneous after reset: req0 and req1 valid same cycle -> req0 granted first,
//    then req1; sustained contention for 6 transactions -> grant 0,1,0,1,0,1.
//  3 Write stability: req1 write addr 0x100 data 0x1234, change req1_addr during ISSUE,
//    delay mem_ready 10 cycles -> mem_addr stays 0x100, mem_wdata 0x1234 every cycle.
//  4 Watchdog: TIMEOUT=8, never assert mem_ready -> ready+err pulse after 8 ISSUE cycles,
//    mem_valid low; next request served normally with err=0.
//  5 Timeout/ready collision: mem_ready on timeout cycle -> ready with err=0, data captured.
//  6 Async reset in ISSUE mid-cycle -> mem_valid low before next edge, no ready pulse,
//    first post-reset tie goes to requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port: one outstanding
// transaction, latched request fields, one-cycle completion pulse, optional watchdog.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_rw,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_rw,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant,
   output logic              busy
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                mem_valid_q, mem_valid_d;
   logic                mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic                busy_q, busy_d;
   logic [1:0]          ready_q, ready_d;
   logic [1:0]          err_q, err_d;
   logic [DATA_W-1:0]   rdata_q [2];
   logic [DATA_W-1:0]   rdata_d [2];
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic any_req;
   logic win_id;
   logic timeout_hit;

   always_comb begin
      any_req     = req0_valid | req1_valid;
      // On a tie the requester that did not win last time goes next.
      win_id      = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mem_valid_q  <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
         ready_q      <= '0;
         err_q        <= '0;
         rdata_q[0]   <= '0;
         rdata_q[1]   <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         mem_valid_q  <= mem_valid_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         err_q        <= err_d;
         rdata_q[0]   <= rdata_d[0];
         rdata_q[1]   <= rdata_d[1];
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = S_ISSUE;
         S_ISSUE: if (mem_ready || timeout_hit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_valid_d  = mem_valid_q;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      busy_d       = (state_d != S_IDLE);
      ready_d      = '0;
      err_d        = '0;
      rdata_d[0]   = rdata_q[0];
      rdata_d[1]   = rdata_q[1];
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d      = win_id;
               last_grant_d = win_id;
               mem_valid_d  = 1'b1;
               mem_rw_d     = win_id ? req1_rw    : req0_rw;
               mem_addr_d   = win_id ? req1_addr  : req0_addr;
               mem_wdata_d  = win_id ? req1_wdata : req0_wdata;
               cnt_d        = '0;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A memory acknowledge wins over a watchdog expiry in the same cycle.
            if (mem_ready) begin
               mem_valid_d       = 1'b0;
               ready_d[grant_q]  = 1'b1;
               rdata_d[grant_q]  = mem_rdata;
            end else if (timeout_hit) begin
               mem_valid_d       = 1'b0;
               ready_d[grant_q]  = 1'b1;
               err_d[grant_q]    = 1'b1;
               rdata_d[grant_q]  = '0;
            end
         end
         default: ;
      endcase
   end

   assign mem_valid  = mem_valid_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign grant      = grant_q;
   assign busy       = busy_q;
   assign req0_ready = ready_q[0];
   assign req1_ready = ready_q[1];
   assign req0_err   = err_q[0];
   assign req1_err   = err_q[1];
   assign req0_rdata = rdata_q[0];
   assign req1_rdata = rdata_q[1];

endmodule
